// File: rtl/burst_line_sequencer_if.sv
// burst_line_sequencer_if: request/response and burst RAM signals of the line sequencer
interface burst_line_sequencer_if #(
  parameter int DEPTH_BITWIDTH = 4,
  parameter int BURST_COUNT = 4
);
  logic req_valid;
  logic req_ready;
  logic req_write;
  logic [DEPTH_BITWIDTH-1:0] req_addr;
  logic [64*BURST_COUNT-1:0] req_wr_line;
  logic rsp_valid;
  logic [64*BURST_COUNT-1:0] rsp_rd_line;
  logic rsp_error;
  logic br_init_calib;
  logic br_busy;
  logic br_cmd;
  logic br_cmd_en;
  logic [DEPTH_BITWIDTH-1:0] br_addr;
  logic [63:0] br_wr_data;
  logic [7:0] br_data_mask;
  logic [63:0] br_rd_data;
  logic br_rd_data_valid;
  modport master (
    output req_valid, req_write, req_addr, req_wr_line, br_init_calib, br_busy, br_rd_data, br_rd_data_valid,
    input req_ready, rsp_valid, rsp_rd_line, rsp_error, br_cmd, br_cmd_en, br_addr, br_wr_data, br_data_mask
  );
  modport slave (
    input req_valid, req_write, req_addr, req_wr_line, br_init_calib, br_busy, br_rd_data, br_rd_data_valid,
    output req_ready, rsp_valid, rsp_rd_line, rsp_error, br_cmd, br_cmd_en, br_addr, br_wr_data, br_data_mask
  );
endinterface

// File: rtl/burst_line_sequencer.sv
// burst_line_sequencer: turns one cache-line request into a single burst RAM command
module burst_line_sequencer #(
  parameter int DEPTH_BITWIDTH = 4,
  parameter int BURST_COUNT = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic clk,
  input logic rst,
  burst_line_sequencer_if.slave bus
);
  localparam int AW = $clog2(BURST_COUNT);
  localparam int BW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WRITE = 2'd1;
  localparam logic [1:0] READ = 2'd2;
  localparam logic [1:0] RESP = 2'd3;
  logic [1:0] state;
  logic [BW-1:0] cnt;
  logic [TW-1:0] tmo;
  logic [64*BURST_COUNT-1:0] line;
  logic [64*BURST_COUNT-1:0] line_nxt;
  logic ready_nxt;
  logic accept;
  logic last_beat;
  logic timed_out;
  assign bus.br_data_mask = '0;
  assign ready_nxt = bus.br_init_calib && !bus.br_busy;
  assign accept = bus.req_valid && bus.req_ready;
  assign last_beat = bus.br_rd_data_valid && cnt == BW'(BURST_COUNT - 1);
  assign timed_out = tmo == TW'(TIMEOUT_CYCLES - 1);
  // line buffer with the current read beat merged in, so completion can publish it in the same edge
  always_comb begin
    line_nxt = line;
    if (state == READ && bus.br_rd_data_valid) line_nxt[{cnt[AW-1:0], 6'd0} +: 64] = bus.br_rd_data;
  end
  // request acceptance, beat sequencing, read collection with timeout, and the response pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      tmo <= '0;
      line <= '0;
      bus.req_ready <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_error <= 1'b0;
      bus.rsp_rd_line <= '0;
      bus.br_cmd <= 1'b0;
      bus.br_cmd_en <= 1'b0;
      bus.br_addr <= '0;
      bus.br_wr_data <= '0;
    end else begin
      bus.br_cmd_en <= 1'b0;
      bus.rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          bus.req_ready <= accept ? 1'b0 : ready_nxt;
          if (accept) begin
            state <= bus.req_write ? WRITE : READ;
            bus.br_cmd_en <= 1'b1;
            bus.br_cmd <= bus.req_write;
            bus.br_addr <= bus.req_addr & ~DEPTH_BITWIDTH'(BURST_COUNT - 1);
            bus.br_wr_data <= bus.req_write ? bus.req_wr_line[63:0] : bus.br_wr_data;
            line <= bus.req_write ? bus.req_wr_line : '0;
            cnt <= bus.req_write ? BW'(1) : '0;
            tmo <= '0;
          end
        end
        WRITE: begin
          if (cnt == BW'(BURST_COUNT)) begin
            state <= RESP;
            bus.rsp_valid <= 1'b1;
            bus.rsp_error <= 1'b0;
          end else begin
            bus.br_wr_data <= line[{cnt[AW-1:0], 6'd0} +: 64];
            cnt <= cnt + BW'(1);
          end
        end
        READ: begin
          tmo <= tmo + TW'(1);
          line <= line_nxt;
          cnt <= bus.br_rd_data_valid ? cnt + BW'(1) : cnt;
          if (last_beat || timed_out) begin
            state <= RESP;
            bus.rsp_valid <= 1'b1;
            bus.rsp_error <= !last_beat;
            bus.rsp_rd_line <= line_nxt;
          end
        end
        RESP: begin
          state <= IDLE;
          bus.req_ready <= ready_nxt;
        end
      endcase
    end
  end
endmodule
